// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port controller: round-robin sharing between requesters A and B.
// Define REGFILE_CLEAR_EN to sweep every register to zero after reset (busy high meanwhile).
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              busy,
  output logic              RegWr,
  output logic [ADDR_W-1:0] Waddr,
  output logic [DATA_W-1:0] Writedata
);

  // Handshake: a requester holds req/addr/data until it sees its one-cycle gnt; while
  // its gnt is high it is not eligible, so a request still held in that cycle is written once.
  logic              ptr_q, ptr_d;  // 0: A wins a tie, 1: B wins a tie
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              a_elig, b_elig, a_win, b_win;
  logic              clearing;

  // The clear sweep walks addresses 0..NREGS-1, so NREGS must equal 2**ADDR_W.
  if (NREGS != (1 << ADDR_W)) begin : g_nregs_mismatch
  end

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // busy is the externally visible view of the FSM state.
  assign clearing = (state_q == ST_CLEAR);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign clearing = 1'b0;
`endif

  assign a_elig = a_req & ~a_gnt_q;
  assign b_elig = b_req & ~b_gnt_q;
  assign a_win  = a_elig & (~b_elig | ~ptr_q);
  assign b_win  = b_elig & ~a_win;

  always_comb begin
    ptr_d   = ptr_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    regwr_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef REGFILE_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
`endif
    if (clearing) begin
`ifdef REGFILE_CLEAR_EN
      regwr_d = 1'b1;
      waddr_d = cnt_q;
      wdata_d = '0;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) state_d = ST_RUN;
`endif
    end else if (a_win) begin
      regwr_d = 1'b1;
      waddr_d = a_addr;
      wdata_d = a_data;
      a_gnt_d = 1'b1;
      ptr_d   = 1'b1;
    end else if (b_win) begin
      regwr_d = 1'b1;
      waddr_d = b_addr;
      wdata_d = b_data;
      b_gnt_d = 1'b1;
      ptr_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_q   <= 1'b0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      regwr_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      regwr_q <= regwr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign busy      = clearing;
  assign RegWr     = regwr_q;
  assign Waddr     = waddr_q;
  assign Writedata = wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed steps plus random traffic against a rule-level model.
// Build with REGFILE_CLEAR_EN defined to also exercise the post-reset clear sweep.
module tb_regfile_wr_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              a_req = 1'b0, b_req = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              a_gnt, b_gnt, busy, RegWr;
  logic [ADDR_W-1:0] Waddr;
  logic [DATA_W-1:0] Writedata;

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .CLK(CLK), .RESET(RESET),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .busy(busy),
    .RegWr(RegWr), .Waddr(Waddr), .Writedata(Writedata)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // register file behind the port plus write scoreboard
  logic [DATA_W-1:0]        rf [NREGS];
  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  always @(negedge CLK) begin
    if (!RESET && RegWr === 1'b1) begin
      rf[Waddr] <= Writedata;
      chk("sb_write_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("sb_write", 64'({Waddr, Writedata}), 64'(exp_q.pop_front()));
    end
  end

  // reference model: who may write this cycle, from the arbitration rules
  int                m_last;      // last winner: 0 = A, 1 = B; tie goes to the other one
  bit                m_ga, m_gb, m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_clear;     // next address to clear, -1 when not clearing

  task automatic model_reset();
    m_last = 1;
    m_ga = 0; m_gb = 0; m_wr = 0;
    m_addr = '0; m_data = '0;
`ifdef REGFILE_CLEAR_EN
    m_clear = 0;
`else
    m_clear = -1;
`endif
  endtask

  task automatic model_clock();
    bit want_a, want_b;
    int who;
    if (m_clear >= 0) begin
      m_wr = 1; m_addr = ADDR_W'(m_clear); m_data = '0;
      m_ga = 0; m_gb = 0;
      m_clear++;
      if (m_clear == NREGS) m_clear = -1;
    end else begin
      want_a = a_req && !m_ga;
      want_b = b_req && !m_gb;
      if (want_a && want_b) who = 1 - m_last;
      else if (want_a)      who = 0;
      else if (want_b)      who = 1;
      else                  who = -1;
      m_ga = (who == 0);
      m_gb = (who == 1);
      m_wr = (who >= 0);
      if (who == 0) begin m_addr = a_addr; m_data = a_data; end
      if (who == 1) begin m_addr = b_addr; m_data = b_data; end
      if (who >= 0) m_last = who;
    end
    if (m_wr) exp_q.push_back({m_addr, m_data});
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_regwr"}, 64'(RegWr), 64'(m_wr));
    chk({pfx, "_waddr"}, 64'(Waddr), 64'(m_addr));
    chk({pfx, "_wdata"}, 64'(Writedata), 64'(m_data));
    chk({pfx, "_a_gnt"}, 64'(a_gnt), 64'(m_ga));
    chk({pfx, "_b_gnt"}, 64'(b_gnt), 64'(m_gb));
    chk({pfx, "_busy"}, 64'(busy), 64'(m_clear >= 0));
  endtask

  // driver tasks
  task automatic set_a(input logic r, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    a_req = r; a_addr = ad; a_data = d;
  endtask

  task automatic set_b(input logic r, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    b_req = r; b_addr = ad; b_data = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    model_clock();
    check_outputs("step");
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset_hold");
    @(negedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic drive_random();
    if (!a_req || a_gnt) begin
      if ($urandom_range(0, 99) < 55) set_a(1'b1, ADDR_W'($urandom_range(0, NREGS - 1)), $urandom);
      else a_req = 1'b0;
    end
    if (!b_req || b_gnt) begin
      if ($urandom_range(0, 99) < 55) set_b(1'b1, ADDR_W'($urandom_range(0, NREGS - 1)), $urandom);
      else b_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();

`ifdef REGFILE_CLEAR_EN
    for (int i = 0; i < 8; i++) begin
      step();
      chk("clr_first_waddr", 64'(Waddr), 64'(i));
    end
    do_reset();
    set_a(1'b1, 4'd9, 32'hC0DE_0009);
    for (int i = 0; i < NREGS; i++) begin
      step();
      chk("clr_waddr", 64'(Waddr), 64'(i));
      chk("clr_regwr", 64'(RegWr), 64'(1));
      chk("clr_wdata", 64'(Writedata), 64'(0));
      chk("clr_busy", 64'(busy), 64'(i < NREGS - 1));
      chk("clr_no_gnt", 64'(a_gnt), 64'(0));
    end
    for (int i = 0; i < NREGS; i++) chk("clr_rf_zero", 64'(rf[i]), 64'(0));
    step();
    chk("post_clear_gnt", 64'(a_gnt), 64'(1));
    set_a(1'b0, '0, '0);
    step();
`else
    chk("busy_tied_low", 64'(busy), 64'(0));
`endif

    set_a(1'b1, 4'd3, 32'h0000_00A5);
    step();
    chk("single_a_gnt", 64'(a_gnt), 64'(1));
    chk("single_regwr", 64'(RegWr), 64'(1));
    chk("single_waddr", 64'(Waddr), 64'(3));
    chk("single_rf3", 64'(rf[3]), 64'(32'hA5));
    set_a(1'b0, '0, '0);
    step();
    chk("idle_regwr", 64'(RegWr), 64'(0));

    set_b(1'b1, 4'd4, 32'h44);
    step();
    chk("single_b_gnt", 64'(b_gnt), 64'(1));
    set_b(1'b0, '0, '0);
    step();

    set_a(1'b1, 4'd1, 32'h11);
    set_b(1'b1, 4'd2, 32'h22);
    step();
    chk("cont1_a_gnt", 64'(a_gnt), 64'(1));
    chk("cont1_b_gnt", 64'(b_gnt), 64'(0));
    set_a(1'b0, '0, '0);
    step();
    chk("cont2_b_gnt", 64'(b_gnt), 64'(1));
    chk("cont2_a_gnt", 64'(a_gnt), 64'(0));
    set_b(1'b0, '0, '0);
    step();
    chk("cont_rf1", 64'(rf[1]), 64'(32'h11));
    chk("cont_rf2", 64'(rf[2]), 64'(32'h22));

    set_a(1'b1, 4'd5, 32'h1);
    set_b(1'b1, 4'd5, 32'h2);
    step();
    set_a(1'b0, '0, '0);
    step();
    set_b(1'b0, '0, '0);
    step();
    chk("same_addr_rf5", 64'(rf[5]), 64'(32'h2));

    set_a(1'b1, 4'd6, 32'h66);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_a_gnt", 64'(a_gnt), 64'(i % 2 == 0));
    end
    set_a(1'b0, '0, '0);
    step();

    set_a(1'b1, 4'd7, 32'h77);
    set_b(1'b1, 4'd8, 32'h88);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("both_held_full_use", 64'(RegWr), 64'(1));
    end
    set_a(1'b0, '0, '0);
    set_b(1'b0, '0, '0);
    step();

    for (int c = 0; c < 400; c++) begin
      drive_random();
      step();
    end

    set_a(1'b1, 4'd10, 32'hAAAA_0010);
    set_b(1'b1, 4'd11, 32'hBBBB_0011);
    do_reset();
    set_a(1'b0, '0, '0);
    set_b(1'b0, '0, '0);
    for (int i = 0; i < NREGS + 2; i++) step();
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
